// File: rtl/sd_test_pkg.sv
// ============================================================================
// sd_test_pkg : shared state encodings and constants for the SD sector tester
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sd_test_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_INIT    = 4'd0;
    localparam state_t ST_IDLE    = 4'd1;
    localparam state_t ST_WR_REQ  = 4'd2;
    localparam state_t ST_WR_WAIT = 4'd3;
    localparam state_t ST_RD_REQ  = 4'd4;
    localparam state_t ST_RD_WAIT = 4'd5;
    localparam state_t ST_NEXT    = 4'd6;
    localparam state_t ST_DONE    = 4'd7;
    localparam state_t ST_FAIL    = 4'd8;

    localparam int SECTOR_BYTES = 512;

    localparam logic SPI_CS_IDLE = 1'b1;
    localparam logic SPI_DI_IDLE = 1'b1;

    typedef enum logic [1:0] {
        SPI_SEL_INIT,
        SPI_SEL_WR,
        SPI_SEL_RD,
        SPI_SEL_IDLE
    } spi_sel_t;

endpackage

`default_nettype wire

// File: rtl/sd_blk_checker.sv
// ============================================================================
// sd_blk_checker : per-block byte pattern compare, length check and
//                  saturating error counter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sd_blk_checker
    import sd_test_pkg::*;
#(
    parameter int ERR_W = 16
) (
    input  logic             SD_clk,
    input  logic             rst_n,
    input  logic             clr_idx,
    input  logic             active,
    input  logic             rd_valid,
    input  logic [7:0]       rd_data,
    input  logic             read_o,
    input  logic             clr_err,
    output logic [ERR_W-1:0] err_cnt
);

    logic [9:0]   byte_idx;
    logic         byte_take;
    logic         byte_err;
    logic [10:0]  byte_total;
    logic         len_err;
    logic [1:0]   err_inc;
    logic [ERR_W:0] err_sum;

    // The length check includes a byte arriving in the same cycle as read_o.
    always_comb begin
        byte_take  = active && rd_valid;
        byte_err   = byte_take && (byte_idx < 10'(SECTOR_BYTES)) && (rd_data != byte_idx[7:0]);
        byte_total = {1'b0, byte_idx} + {10'd0, byte_take};
        len_err    = active && read_o && (byte_total != 11'(SECTOR_BYTES));
        err_inc    = {1'b0, byte_err} + {1'b0, len_err};
        err_sum    = {1'b0, err_cnt} + {{(ERR_W-1){1'b0}}, err_inc};
    end

    // byte_idx sticks at its maximum so very long blocks still fail the length check.
    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
            err_cnt  <= '0;
        end else begin
            if (clr_idx)
                byte_idx <= '0;
            else if (byte_take && (byte_idx != 10'h3FF))
                byte_idx <= byte_idx + 10'd1;

            if (clr_err)
                err_cnt <= '0;
            else if (err_inc != 2'd0)
                err_cnt <= err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sd_multi_sector_test.sv
// ============================================================================
// sd_multi_sector_test : multi-sector SD (SPI mode) write / read-back / verify
//                        sequencer with SPI line mux and timeout
// Revision             : 1.0
// ============================================================================
`default_nettype none

module sd_multi_sector_test
    import sd_test_pkg::*;
#(
    parameter logic [31:0] START_SEC = 32'd0,
    parameter int          NUM_SEC   = 8,
    parameter int          MODE      = 0,
    parameter int          LOOP      = 0,
    parameter int          TIMEOUT   = 2**20,
    parameter int          ERR_W     = 16
) (
    input  logic             SD_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             init_o,
    input  logic             cs_i,
    input  logic             di_i,
    input  logic             cs_w,
    input  logic             di_w,
    input  logic             cs_r,
    input  logic             di_r,
    output logic             SD_cs,
    output logic             SD_datain,
    output logic             write_req,
    output logic [31:0]      write_sec,
    input  logic             write_o,
    output logic             read_req,
    output logic [31:0]      read_sec,
    input  logic             read_o,
    input  logic [7:0]       rd_data,
    input  logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic [15:0]      pass_cnt,
    output logic [31:0]      cur_sec,
    output logic [3:0]       state_o
);

    localparam int          TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [31:0] LAST_SEC  = START_SEC + 32'(NUM_SEC - 1);
    localparam state_t      FIRST_REQ = (MODE != 0) ? ST_RD_REQ : ST_WR_REQ;

    state_t     state;
    state_t     state_next;
    logic [TMO_W-1:0] tmo;
    logic       tmo_hit;
    logic       timed;
    logic       auto_run;
    logic       at_last;
    logic       restart;
    spi_sel_t   spi_sel;

    assign tmo_hit = (tmo == TMO_W'(TIMEOUT - 1));
    assign at_last = (cur_sec == LAST_SEC);
    assign restart = ((state == ST_DONE) || (state == ST_FAIL)) && start;

    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_INIT;
        else
            state <= state_next;
    end

    // Completion inputs take priority over a timeout in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:    if (init_o) state_next = ST_IDLE;
                        else if (tmo_hit) state_next = ST_FAIL;
            ST_IDLE:    if (start || auto_run) state_next = FIRST_REQ;
            ST_WR_REQ:  state_next = ST_WR_WAIT;
            ST_WR_WAIT: if (write_o) state_next = ST_RD_REQ;
                        else if (tmo_hit) state_next = ST_FAIL;
            ST_RD_REQ:  state_next = ST_RD_WAIT;
            ST_RD_WAIT: if (read_o) state_next = ST_NEXT;
                        else if (tmo_hit) state_next = ST_FAIL;
            ST_NEXT:    state_next = (at_last && (LOOP == 0)) ? ST_DONE : FIRST_REQ;
            ST_DONE,
            ST_FAIL:    if (start) state_next = init_o ? FIRST_REQ : ST_INIT;
            default:    state_next = ST_INIT;
        endcase
    end

    always_comb begin
        write_req = (state == ST_WR_REQ);
        read_req  = (state == ST_RD_REQ);
        busy      = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_FAIL);
        done      = (state == ST_DONE);
        fail      = (state == ST_FAIL);
        timed     = (state == ST_INIT) || (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
        case (state)
            ST_INIT:                spi_sel = SPI_SEL_INIT;
            ST_WR_REQ, ST_WR_WAIT:  spi_sel = SPI_SEL_WR;
            ST_RD_REQ, ST_RD_WAIT:  spi_sel = SPI_SEL_RD;
            default:                spi_sel = SPI_SEL_IDLE;
        endcase
    end

    always_comb begin
        SD_cs     = SPI_CS_IDLE;
        SD_datain = SPI_DI_IDLE;
        case (spi_sel)
            SPI_SEL_INIT: begin SD_cs = cs_i; SD_datain = di_i; end
            SPI_SEL_WR:   begin SD_cs = cs_w; SD_datain = di_w; end
            SPI_SEL_RD:   begin SD_cs = cs_r; SD_datain = di_r; end
            default:      begin SD_cs = SPI_CS_IDLE; SD_datain = SPI_DI_IDLE; end
        endcase
    end

    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n)
            tmo <= '0;
        else if (state_next != state)
            tmo <= '0;
        else if (timed)
            tmo <= tmo + {{(TMO_W-1){1'b0}}, 1'b1};
    end

    // The first visit to IDLE after reset launches a run without a start pulse.
    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n)
            auto_run <= 1'b1;
        else if (state == ST_IDLE)
            auto_run <= 1'b0;
    end

    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sec  <= START_SEC;
            pass_cnt <= 16'd0;
        end else if (state == ST_NEXT) begin
            if (at_last) begin
                pass_cnt <= pass_cnt + 16'd1;
                cur_sec  <= START_SEC;
            end else begin
                cur_sec  <= cur_sec + 32'd1;
            end
        end else if (restart) begin
            cur_sec <= START_SEC;
        end
    end

    assign write_sec = cur_sec;
    assign read_sec  = cur_sec;
    assign state_o   = state;

    sd_blk_checker #(
        .ERR_W (ERR_W)
    ) u_checker (
        .SD_clk   (SD_clk),
        .rst_n    (rst_n),
        .clr_idx  (state == ST_RD_REQ),
        .active   (state == ST_RD_WAIT),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .read_o   (read_o),
        .clr_err  (restart),
        .err_cnt  (err_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_sd_multi_sector_test.sv
// ============================================================================
// tb_sd_multi_sector_test : directed bench for sd_multi_sector_test
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_sd_multi_sector_test;

    logic SD_clk = 1'b0;
    always #5 SD_clk = ~SD_clk;

    // index 0: START=0 NUM=3 TIMEOUT=2048; index 1: START=FFFFFFFF NUM=2 LOOP TIMEOUT=64 ERR_W=2
    logic        rst_n    [2];
    logic        start    [2];
    logic        init_o   [2];
    logic        write_o  [2];
    logic        read_o   [2];
    logic        rd_valid [2];
    logic [7:0]  rd_data  [2];
    logic        sd_cs    [2];
    logic        sd_di    [2];
    logic        write_req[2];
    logic        read_req [2];
    logic        busy     [2];
    logic        done     [2];
    logic        fail     [2];
    logic [31:0] write_sec[2];
    logic [31:0] read_sec [2];
    logic [31:0] cur_sec  [2];
    logic [15:0] pass_cnt [2];
    logic [3:0]  state_o  [2];
    logic [15:0] err_a;
    logic [1:0]  err_b;

    logic cs_i = 1'b0, di_i = 1'b1;
    logic cs_w = 1'b1, di_w = 1'b0;
    logic cs_r = 1'b0, di_r = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    sd_multi_sector_test #(
        .START_SEC (32'd0), .NUM_SEC (3), .MODE (0), .LOOP (0), .TIMEOUT (2048), .ERR_W (16)
    ) dut_a (
        .SD_clk (SD_clk), .rst_n (rst_n[0]), .start (start[0]), .init_o (init_o[0]),
        .cs_i (cs_i), .di_i (di_i), .cs_w (cs_w), .di_w (di_w), .cs_r (cs_r), .di_r (di_r),
        .SD_cs (sd_cs[0]), .SD_datain (sd_di[0]),
        .write_req (write_req[0]), .write_sec (write_sec[0]), .write_o (write_o[0]),
        .read_req (read_req[0]), .read_sec (read_sec[0]), .read_o (read_o[0]),
        .rd_data (rd_data[0]), .rd_valid (rd_valid[0]),
        .busy (busy[0]), .done (done[0]), .fail (fail[0]), .err_cnt (err_a),
        .pass_cnt (pass_cnt[0]), .cur_sec (cur_sec[0]), .state_o (state_o[0])
    );

    sd_multi_sector_test #(
        .START_SEC (32'hFFFF_FFFF), .NUM_SEC (2), .MODE (0), .LOOP (1), .TIMEOUT (64), .ERR_W (2)
    ) dut_b (
        .SD_clk (SD_clk), .rst_n (rst_n[1]), .start (start[1]), .init_o (init_o[1]),
        .cs_i (cs_i), .di_i (di_i), .cs_w (cs_w), .di_w (di_w), .cs_r (cs_r), .di_r (di_r),
        .SD_cs (sd_cs[1]), .SD_datain (sd_di[1]),
        .write_req (write_req[1]), .write_sec (write_sec[1]), .write_o (write_o[1]),
        .read_req (read_req[1]), .read_sec (read_sec[1]), .read_o (read_o[1]),
        .rd_data (rd_data[1]), .rd_valid (rd_valid[1]),
        .busy (busy[1]), .done (done[1]), .fail (fail[1]), .err_cnt (err_b),
        .pass_cnt (pass_cnt[1]), .cur_sec (cur_sec[1]), .state_o (state_o[1])
    );

    task automatic wait_state(input int d, input logic [3:0] st, input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget) begin
            if (state_o[d] === st) begin
                ok = 1'b1;
                return;
            end
            @(negedge SD_clk);
            n++;
        end
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        @(negedge SD_clk);
        start[d] = 1'b0;
    endtask

    // One write + read-back of a sector; returns while the DUT sits in NEXT.
    task automatic do_sector(input int d, input int nbytes, input int bad, input bit same,
                             output logic [31:0] wsec, output logic [31:0] rsec,
                             output logic wreq_now, output logic wreq_after, output logic rreq_now,
                             output logic [1:0] mux_w, output logic [1:0] mux_r, output bit ok);
        bit okw;
        wsec = 'x; rsec = 'x; wreq_now = 1'bx; wreq_after = 1'bx; rreq_now = 1'bx;
        mux_w = 2'bxx; mux_r = 2'bxx;
        wait_state(d, 4'd2, 40, okw);
        ok = okw;
        if (!okw) return;
        wsec = write_sec[d];
        wreq_now = write_req[d];
        @(negedge SD_clk);
        wreq_after = write_req[d];
        mux_w = {sd_cs[d], sd_di[d]};
        write_o[d] = 1'b1;
        @(negedge SD_clk);
        write_o[d] = 1'b0;
        wait_state(d, 4'd4, 8, okw);
        ok = okw;
        if (!okw) return;
        rsec = read_sec[d];
        rreq_now = read_req[d];
        @(negedge SD_clk);
        mux_r = {sd_cs[d], sd_di[d]};
        for (int i = 0; i < nbytes; i++) begin
            rd_valid[d] = 1'b1;
            if (i == bad)      rd_data[d] = 8'(i) + 8'd1;
            else if (i >= 512) rd_data[d] = 8'hAA;
            else               rd_data[d] = 8'(i);
            if (same && (i == nbytes - 1)) read_o[d] = 1'b1;
            @(negedge SD_clk);
        end
        rd_valid[d] = 1'b0;
        if (!same) begin
            read_o[d] = 1'b1;
            @(negedge SD_clk);
        end
        read_o[d] = 1'b0;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; start[d] = 1'b0; init_o[d] = 1'b0; write_o[d] = 1'b0;
            read_o[d] = 1'b0; rd_valid[d] = 1'b0; rd_data[d] = 8'h00;
        end
        repeat (3) @(negedge SD_clk);
        n_cmp++; if (state_o[0] !== 4'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state_o[0]); end
        n_cmp++; if (write_req[0] !== 1'b0 || read_req[0] !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b%b want 00", write_req[0], read_req[0]); end
        n_cmp++; if (write_sec[0] !== 32'd0 || read_sec[0] !== 32'd0 || cur_sec[0] !== 32'd0) begin n_bad++; $display("FAIL reset_sec got %h/%h/%h want 0", write_sec[0], read_sec[0], cur_sec[0]); end
        n_cmp++; if (err_a !== 16'd0 || pass_cnt[0] !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got err %0d pass %0d want 0 0", err_a, pass_cnt[0]); end
        n_cmp++; if ({busy[0], done[0], fail[0]} !== 3'b100) begin n_bad++; $display("FAIL reset_flags got %b want 100", {busy[0], done[0], fail[0]}); end
        n_cmp++; if ({sd_cs[0], sd_di[0]} !== 2'b01) begin n_bad++; $display("FAIL reset_mux got %b want 01", {sd_cs[0], sd_di[0]}); end
        n_cmp++; if (cur_sec[1] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_start_sec got %h want ffffffff", cur_sec[1]); end
        rst_n[0] = 1'b1;
        init_o[0] = 1'b1;
    endtask

    task automatic test_basic;
        logic [31:0] ws, rs;
        logic wn, wa, rn;
        logic [1:0] mw, mr;
        bit ok, okd;
        for (int s = 0; s < 3; s++) begin
            do_sector(0, 512, -1, (s == 2), ws, rs, wn, wa, rn, mw, mr, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_handshake sec %0d got ok 0 want 1", s); end
            n_cmp++; if (ws !== 32'(s) || rs !== 32'(s)) begin n_bad++; $display("FAIL basic_sector got w %h r %h want %0d", ws, rs, s); end
            if (s == 0) begin
                n_cmp++; if ({wn, wa, rn} !== 3'b101) begin n_bad++; $display("FAIL basic_req_pulse got %b want 101", {wn, wa, rn}); end
                n_cmp++; if (mw !== 2'b10 || mr !== 2'b00) begin n_bad++; $display("FAIL basic_mux got w %b r %b want 10 00", mw, mr); end
            end
        end
        wait_state(0, 4'd7, 5, okd);
        n_cmp++; if (!okd) begin n_bad++; $display("FAIL basic_done got state %0d want 7", state_o[0]); end
        n_cmp++; if ({busy[0], done[0], fail[0]} !== 3'b010) begin n_bad++; $display("FAIL basic_flags got %b want 010", {busy[0], done[0], fail[0]}); end
        n_cmp++; if (err_a !== 16'd0 || pass_cnt[0] !== 16'd1 || cur_sec[0] !== 32'd0) begin n_bad++; $display("FAIL basic_counts got err %0d pass %0d cur %h want 0 1 0", err_a, pass_cnt[0], cur_sec[0]); end
        n_cmp++; if ({sd_cs[0], sd_di[0]} !== 2'b11) begin n_bad++; $display("FAIL basic_idle_mux got %b want 11", {sd_cs[0], sd_di[0]}); end
    endtask

    task automatic test_short_long;
        logic [31:0] ws, rs;
        logic wn, wa, rn;
        logic [1:0] mw, mr;
        bit ok, okd;
        pulse_start(0);
        do_sector(0, 511, -1, 1'b0, ws, rs, wn, wa, rn, mw, mr, ok);
        n_cmp++; if (!ok || err_a !== 16'd1) begin n_bad++; $display("FAIL short_block got err %0d ok %0d want 1 1", err_a, ok); end
        do_sector(0, 513, -1, 1'b0, ws, rs, wn, wa, rn, mw, mr, ok);
        n_cmp++; if (!ok || err_a !== 16'd2) begin n_bad++; $display("FAIL long_block got err %0d ok %0d want 2 1", err_a, ok); end
        do_sector(0, 512, -1, 1'b0, ws, rs, wn, wa, rn, mw, mr, ok);
        wait_state(0, 4'd7, 5, okd);
        n_cmp++; if (!okd || err_a !== 16'd2 || pass_cnt[0] !== 16'd2) begin n_bad++; $display("FAIL short_long_end got state %0d err %0d pass %0d want 7 2 2", state_o[0], err_a, pass_cnt[0]); end
    endtask

    task automatic test_corrupt;
        logic [31:0] ws, rs;
        logic wn, wa, rn;
        logic [1:0] mw, mr;
        bit ok, okd;
        pulse_start(0);
        n_cmp++; if (state_o[0] !== 4'd2 || err_a !== 16'd0 || cur_sec[0] !== 32'd0) begin n_bad++; $display("FAIL restart got state %0d err %0d cur %h want 2 0 0", state_o[0], err_a, cur_sec[0]); end
        do_sector(0, 512, -1, 1'b0, ws, rs, wn, wa, rn, mw, mr, ok);
        do_sector(0, 512, 100, 1'b0, ws, rs, wn, wa, rn, mw, mr, ok);
        n_cmp++; if (!ok || err_a !== 16'd1 || rs !== 32'd1) begin n_bad++; $display("FAIL corrupt_byte got err %0d sec %h want 1 1", err_a, rs); end
        do_sector(0, 512, -1, 1'b0, ws, rs, wn, wa, rn, mw, mr, ok);
        wait_state(0, 4'd7, 5, okd);
        n_cmp++; if (!okd || done[0] !== 1'b1 || err_a !== 16'd1 || pass_cnt[0] !== 16'd3) begin n_bad++; $display("FAIL corrupt_end got state %0d err %0d pass %0d want 7 1 3", state_o[0], err_a, pass_cnt[0]); end
    endtask

    task automatic test_loop;
        logic [31:0] ws, rs;
        logic wn, wa, rn;
        logic [1:0] mw, mr;
        logic [31:0] exp_sec;
        bit ok;
        rst_n[1] = 1'b1;
        init_o[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_sec = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'd0;
            do_sector(1, 4, -1, 1'b0, ws, rs, wn, wa, rn, mw, mr, ok);
            n_cmp++; if (!ok || ws !== exp_sec || rs !== exp_sec) begin n_bad++; $display("FAIL loop_sector %0d got w %h r %h want %h", k, ws, rs, exp_sec); end
            n_cmp++; if (err_b !== ((k < 3) ? 2'(k + 1) : 2'd3)) begin n_bad++; $display("FAIL loop_err_sat %0d got %0d want %0d", k, err_b, (k < 3) ? k + 1 : 3); end
            @(negedge SD_clk);
            if (k % 2 == 1) begin
                n_cmp++; if (pass_cnt[1] !== 16'((k + 1) / 2) || done[1] !== 1'b0 || busy[1] !== 1'b1) begin n_bad++; $display("FAIL loop_pass got pass %0d done %b busy %b want %0d 0 1", pass_cnt[1], done[1], busy[1], (k + 1) / 2); end
            end
        end
    endtask

    task automatic test_timeout;
        bit ok;
        wait_state(1, 4'd2, 8, ok);
        n_cmp++; if (!ok || write_sec[1] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL timeout_req got state %0d sec %h want 2 ffffffff", state_o[1], write_sec[1]); end
        @(negedge SD_clk);
        repeat (63) @(negedge SD_clk);
        n_cmp++; if (state_o[1] !== 4'd3) begin n_bad++; $display("FAIL timeout_early got state %0d want 3", state_o[1]); end
        @(negedge SD_clk);
        n_cmp++; if (state_o[1] !== 4'd8 || fail[1] !== 1'b1 || busy[1] !== 1'b0) begin n_bad++; $display("FAIL timeout_fail got state %0d fail %b busy %b want 8 1 0", state_o[1], fail[1], busy[1]); end
        n_cmp++; if ({sd_cs[1], sd_di[1]} !== 2'b11) begin n_bad++; $display("FAIL timeout_mux got %b want 11", {sd_cs[1], sd_di[1]}); end
    endtask

    task automatic test_reset_mid;
        pulse_start(1);
        n_cmp++; if (state_o[1] !== 4'd2 || err_b !== 2'd0 || fail[1] !== 1'b0) begin n_bad++; $display("FAIL fail_restart got state %0d err %0d fail %b want 2 0 0", state_o[1], err_b, fail[1]); end
        @(negedge SD_clk);
        write_o[1] = 1'b1;
        @(negedge SD_clk);
        write_o[1] = 1'b0;
        @(negedge SD_clk);
        rd_valid[1] = 1'b1; rd_data[1] = 8'h00;
        @(negedge SD_clk);
        rd_data[1] = 8'h55;
        @(negedge SD_clk);
        rd_valid[1] = 1'b0;
        n_cmp++; if (err_b !== 2'd1) begin n_bad++; $display("FAIL mid_byte_err got %0d want 1", err_b); end
        pulse_start(1);
        n_cmp++; if (state_o[1] !== 4'd5 || busy[1] !== 1'b1) begin n_bad++; $display("FAIL start_ignored got state %0d busy %b want 5 1", state_o[1], busy[1]); end
        rst_n[1] = 1'b0;
        #1;
        n_cmp++; if (state_o[1] !== 4'd0 || read_req[1] !== 1'b0 || write_req[1] !== 1'b0) begin n_bad++; $display("FAIL mid_reset_state got state %0d req %b%b want 0 00", state_o[1], write_req[1], read_req[1]); end
        n_cmp++; if (err_b !== 2'd0 || pass_cnt[1] !== 16'd0 || cur_sec[1] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mid_reset_cnt got err %0d pass %0d cur %h want 0 0 ffffffff", err_b, pass_cnt[1], cur_sec[1]); end
        n_cmp++; if ({sd_cs[1], sd_di[1]} !== 2'b01) begin n_bad++; $display("FAIL mid_reset_mux got %b want 01", {sd_cs[1], sd_di[1]}); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_short_long;
        test_corrupt;
        test_loop;
        test_timeout;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
